// File: rtl/de_scoreboard.sv
// Decode-stage register file with per-register in-flight write counters.
// Sources stall while writes are outstanding; same-cycle write-back bypasses into the read ports.
module de_scoreboard #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int REGWORDS  = 32,
  parameter int NUM_WB    = 1,
  parameter int CNTBITS   = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [REGNOBITS-1:0]          rs1_i,
  input  logic [REGNOBITS-1:0]          rs2_i,
  input  logic                          rs1_used_i,
  input  logic                          rs2_used_i,
  input  logic [REGNOBITS-1:0]          rd_i,
  input  logic                          rd_wr_i,
  output logic [DBITS-1:0]              rs1_data_o,
  output logic [DBITS-1:0]              rs2_data_o,
  output logic                          stall_o,
  input  logic [NUM_WB-1:0]             wb_valid_i,
  input  logic [NUM_WB*REGNOBITS-1:0]   wb_regno_i,
  input  logic [NUM_WB*DBITS-1:0]       wb_data_i,
  input  logic                          kill_valid_i,
  input  logic [REGNOBITS-1:0]          kill_regno_i,
  output logic [REGWORDS-1:0]           busy_mask_o,
  output logic                          err_underflow_o
);

  // Wide enough to hold count + one issue, and every port plus the kill decrementing at once.
  localparam int SW = CNTBITS + $clog2(NUM_WB + 2) + 1;
  localparam logic [CNTBITS-1:0] CNT_MAX = '1;

  logic [DBITS-1:0]     regs_q [REGWORDS];
  logic [DBITS-1:0]     regs_d [REGWORDS];
  logic [CNTBITS-1:0]   cnt_q  [REGWORDS];
  logic [CNTBITS-1:0]   cnt_d  [REGWORDS];
  logic                 err_q, err_d;

  logic [REGNOBITS-1:0] wb_reg [NUM_WB];
  logic [DBITS-1:0]     wb_dat [NUM_WB];
  logic [SW-1:0]        dec_v  [REGWORDS];
  logic [SW-1:0]        sum_v  [REGWORDS];

  logic [SW-1:0]        rs1_hits, rs2_hits;
  logic [DBITS-1:0]     rs1_data, rs2_data;
  logic                 src1_haz, src2_haz, dst_haz, fire;

  always_comb begin
    for (int k = 0; k < NUM_WB; k++) begin
      wb_reg[k] = wb_regno_i[k*REGNOBITS +: REGNOBITS];
      wb_dat[k] = wb_data_i[k*DBITS +: DBITS];
    end
  end

  // Highest-index matching port overrides, so iterate upward and let later ports win.
  always_comb begin
    rs1_hits = '0;
    rs2_hits = '0;
    rs1_data = regs_q[rs1_i];
    rs2_data = regs_q[rs2_i];
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid_i[k] && wb_reg[k] != '0) begin
        if (wb_reg[k] == rs1_i) begin
          rs1_hits = rs1_hits + SW'(1);
          rs1_data = wb_dat[k];
        end
        if (wb_reg[k] == rs2_i) begin
          rs2_hits = rs2_hits + SW'(1);
          rs2_data = wb_dat[k];
        end
      end
    end
    if (rs1_i == '0) rs1_data = '0;
    if (rs2_i == '0) rs2_data = '0;
  end

  assign src1_haz = rs1_used_i && (rs1_i != '0) && (SW'(cnt_q[rs1_i]) > rs1_hits);
  assign src2_haz = rs2_used_i && (rs2_i != '0) && (SW'(cnt_q[rs2_i]) > rs2_hits);
  assign dst_haz  = rd_wr_i && (rd_i != '0) && (cnt_q[rd_i] == CNT_MAX);

  assign issue_ready_o   = ~(src1_haz | src2_haz | dst_haz);
  assign stall_o         = issue_valid_i & ~issue_ready_o;
  assign fire            = issue_valid_i & issue_ready_o;
  assign rs1_data_o      = rs1_data;
  assign rs2_data_o      = rs2_data;
  assign err_underflow_o = err_q;

  always_comb begin
    for (int r = 0; r < REGWORDS; r++) begin
      busy_mask_o[r] = (cnt_q[r] != '0);
    end
  end

  // x0 is skipped entirely: never written, never counted.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < REGWORDS; r++) begin
      cnt_d[r]  = cnt_q[r];
      regs_d[r] = regs_q[r];
      dec_v[r]  = '0;
      sum_v[r]  = '0;
    end
    for (int r = 1; r < REGWORDS; r++) begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid_i[k] && wb_reg[k] == REGNOBITS'(r)) begin
          dec_v[r]  = dec_v[r] + SW'(1);
          regs_d[r] = wb_dat[k];
        end
      end
      if (kill_valid_i && kill_regno_i == REGNOBITS'(r)) dec_v[r] = dec_v[r] + SW'(1);
      sum_v[r] = SW'(cnt_q[r]) + SW'(fire && rd_wr_i && rd_i == REGNOBITS'(r));
      if (dec_v[r] > sum_v[r]) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = CNTBITS'(sum_v[r] - dec_v[r]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < REGWORDS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < REGWORDS; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_de_scoreboard.sv
// Scoreboard bench for de_scoreboard with two write-back ports: directed scenarios then random traffic.
module tb_de_scoreboard;

  localparam int DBITS = 32;
  localparam int RB    = 5;
  localparam int RW    = 32;
  localparam int NWB   = 2;
  localparam int CB    = 2;
  localparam int CMAX  = (1 << CB) - 1;

  typedef struct packed {
    logic          valid;
    logic [RB-1:0] rs1;
    logic          rs1u;
    logic [RB-1:0] rs2;
    logic          rs2u;
    logic [RB-1:0] rd;
    logic          rdwr;
    logic [1:0]    wbv;
    logic [RB-1:0] wbr0;
    logic [RB-1:0] wbr1;
    logic [31:0]   wbd0;
    logic [31:0]   wbd1;
    logic          kv;
    logic [RB-1:0] kr;
  } stim_t;

  typedef struct packed {
    logic        ready;
    logic        stall;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 issue_valid, rs1_used, rs2_used, rd_wr, kill_valid;
  logic [RB-1:0]        rs1, rs2, rd, kill_regno;
  logic [NWB-1:0]       wb_valid;
  logic [NWB*RB-1:0]    wb_regno;
  logic [NWB*DBITS-1:0] wb_data;
  logic                 issue_ready, stall, err_underflow;
  logic [DBITS-1:0]     rs1_data, rs2_data;
  logic [RW-1:0]        busy_mask;

  de_scoreboard #(.DBITS(DBITS), .REGNOBITS(RB), .REGWORDS(RW), .NUM_WB(NWB), .CNTBITS(CB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .rs1_i(rs1), .rs2_i(rs2), .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
    .rd_i(rd), .rd_wr_i(rd_wr),
    .rs1_data_o(rs1_data), .rs2_data_o(rs2_data), .stall_o(stall),
    .wb_valid_i(wb_valid), .wb_regno_i(wb_regno), .wb_data_i(wb_data),
    .kill_valid_i(kill_valid), .kill_regno_i(kill_regno),
    .busy_mask_o(busy_mask), .err_underflow_o(err_underflow)
  );

  always #5 clk = ~clk;

  int          mcnt  [RW];
  logic [31:0] mregs [RW];
  bit          merr;
  exp_t        expq [$];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
    else n_pass++;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < RW; r++) begin
      mcnt[r]  = 0;
      mregs[r] = '0;
    end
    merr = 1'b0;
  endfunction

  function automatic int wb_hits(input stim_t s, input logic [RB-1:0] r);
    int n = 0;
    if (r == 0) return 0;
    if (s.wbv[0] && s.wbr0 == r) n++;
    if (s.wbv[1] && s.wbr1 == r) n++;
    return n;
  endfunction

  function automatic logic [31:0] read_src(input stim_t s, input logic [RB-1:0] r);
    if (r == 0) return '0;
    if (s.wbv[1] && s.wbr1 == r) return s.wbd1;
    if (s.wbv[0] && s.wbr0 == r) return s.wbd0;
    return mregs[r];
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit h1, h2, hd;
    h1 = s.rs1u && s.rs1 != 0 && mcnt[s.rs1] > wb_hits(s, s.rs1);
    h2 = s.rs2u && s.rs2 != 0 && mcnt[s.rs2] > wb_hits(s, s.rs2);
    hd = s.rdwr && s.rd != 0 && mcnt[s.rd] == CMAX;
    e.ready = !(h1 || h2 || hd);
    e.stall = s.valid && !e.ready;
    e.d1    = read_src(s, s.rs1);
    e.d2    = read_src(s, s.rs2);
    for (int r = 0; r < RW; r++) e.busy[r] = (mcnt[r] != 0);
    e.err   = merr;
    return e;
  endfunction

  function automatic void model_clock(input stim_t s, input bit fire);
    int delta [RW];
    for (int r = 0; r < RW; r++) delta[r] = 0;
    if (fire && s.rdwr) delta[s.rd] += 1;
    if (s.wbv[0]) begin delta[s.wbr0] -= 1; mregs[s.wbr0] = s.wbd0; end
    if (s.wbv[1]) begin delta[s.wbr1] -= 1; mregs[s.wbr1] = s.wbd1; end
    if (s.kv) delta[s.kr] -= 1;
    mregs[0] = '0;
    for (int r = 1; r < RW; r++) begin
      mcnt[r] += delta[r];
      if (mcnt[r] < 0) begin
        mcnt[r] = 0;
        merr = 1'b1;
      end
    end
  endfunction

  task automatic apply(input stim_t s);
    issue_valid = s.valid;
    rs1 = s.rs1; rs1_used = s.rs1u;
    rs2 = s.rs2; rs2_used = s.rs2u;
    rd = s.rd;   rd_wr = s.rdwr;
    wb_valid = s.wbv;
    wb_regno = {s.wbr1, s.wbr0};
    wb_data  = {s.wbd1, s.wbd0};
    kill_valid = s.kv; kill_regno = s.kr;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    apply(s);
    #1;
    e = predict(s);
    expq.push_back(e);
    model_clock(s, s.valid && e.ready);
  endtask

  task automatic issue_rd(input logic [RB-1:0] r);
    stim_t s = idle();
    s.valid = 1'b1; s.rd = r; s.rdwr = 1'b1;
    step(s);
  endtask

  // Monitor: the DUT is combinational on the read side, so it presents a response every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (expq.size() > 0) begin
        e = expq.pop_front();
        chk("issue_ready", 64'(issue_ready), 64'(e.ready));
        chk("stall",       64'(stall),       64'(e.stall));
        chk("rs1_data",    64'(rs1_data),    64'(e.d1));
        chk("rs2_data",    64'(rs2_data),    64'(e.d2));
        chk("busy_mask",   64'(busy_mask),   64'(e.busy));
        chk("err_underflow", 64'(err_underflow), 64'(e.err));
      end
    end
  end

  function automatic stim_t rand_stim();
    stim_t s = idle();
    int avail [8];
    logic [RB-1:0] r;
    for (int i = 0; i < 8; i++) avail[i] = mcnt[i];
    s.valid = ($urandom_range(0, 3) != 0);
    s.rs1 = RB'($urandom_range(0, 7)); s.rs1u = 1'($urandom_range(0, 1));
    s.rs2 = RB'($urandom_range(0, 7)); s.rs2u = 1'($urandom_range(0, 1));
    s.rd  = RB'($urandom_range(0, 7)); s.rdwr = 1'($urandom_range(0, 1));
    for (int k = 0; k < 2; k++) begin
      r = RB'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1 && (r == 0 || avail[r] > 0 || $urandom_range(0, 40) == 0)) begin
        avail[r]--;
        s.wbv[k] = 1'b1;
        if (k == 0) begin s.wbr0 = r; s.wbd0 = $urandom; end
        else        begin s.wbr1 = r; s.wbd1 = $urandom; end
      end
    end
    r = RB'($urandom_range(0, 7));
    if ($urandom_range(0, 5) == 0 && (avail[r] > 0 || $urandom_range(0, 40) == 0)) begin
      s.kv = 1'b1; s.kr = r;
    end
    return s;
  endfunction

  initial begin
    stim_t s;
    exp_t  e;
    apply(idle());
    model_reset();
    #12 rst_n = 1'b1;

    step(idle());

    // Source hazard, then resolved by same-cycle write-back with bypass
    issue_rd(5);
    s = idle(); s.valid = 1'b1; s.rs1 = 5; s.rs1u = 1'b1;
    step(s);
    s.wbv = 2'b01; s.wbr0 = 5; s.wbd0 = 32'hDEADBEEF;
    step(s);
    s = idle(); s.rs2 = 5; s.rs2u = 1'b1;
    step(s);

    // Saturation of in-flight count and destination hazard
    issue_rd(7); issue_rd(7); issue_rd(7);
    issue_rd(7);
    s = idle(); s.wbv = 2'b01; s.wbr0 = 7; s.wbd0 = 32'h7777_0001;
    step(s);
    s = idle(); s.valid = 1'b1; s.rd = 7; s.rdwr = 1'b1;
    s.wbv = 2'b10; s.wbr1 = 7; s.wbd1 = 32'h7777_0002;
    step(s);
    s = idle(); s.rs1 = 7; s.rs1u = 1'b1;
    step(s);

    // Kill release then underflow
    issue_rd(9);
    s = idle(); s.kv = 1'b1; s.kr = 9; s.rs1 = 9; s.rs1u = 1'b1;
    step(s);
    s = idle(); s.rs1 = 9;
    step(s);
    s = idle(); s.kv = 1'b1; s.kr = 9;
    step(s);
    step(idle());
    step(idle());

    // Two ports hitting the same register: higher port wins
    issue_rd(3); issue_rd(3);
    s = idle(); s.valid = 1'b1; s.rs1 = 3; s.rs1u = 1'b1; s.rs2 = 3;
    s.wbv = 2'b11; s.wbr0 = 3; s.wbd0 = 32'h11; s.wbr1 = 3; s.wbd1 = 32'h22;
    step(s);
    s = idle(); s.rs1 = 3; s.rs1u = 1'b1;
    step(s);

    // x0 is never counted nor written
    s = idle(); s.valid = 1'b1; s.rd = 0; s.rdwr = 1'b1;
    s.wbv = 2'b01; s.wbr0 = 0; s.wbd0 = 32'hFF; s.rs1 = 0; s.rs1u = 1'b1;
    step(s);
    s = idle(); s.rs1 = 0; s.rs1u = 1'b1;
    step(s);

    // Asynchronous reset mid-operation, observed before any clock edge
    issue_rd(4); issue_rd(4);
    s = idle(); s.rs1 = 4; s.rs2 = 5;
    @(negedge clk);
    apply(s);
    rst_n = 1'b0;
    #1;
    model_reset();
    e = predict(s);
    expq.push_back(e);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 500; i++) step(rand_stim());

    @(negedge clk);
    #3;
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
